// File: rtl/capacitance_scan_controller_if.sv
// capacitance_scan_controller_if: host-side scan command and result handshake
// start/chan_mask: scan request; result/result_chan/timeout_flag: payload;
// result_valid/result_ready: result handshake (master = host, slave = controller)
interface capacitance_scan_controller_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 24
);
  localparam int SEL_W = $clog2(CHANNELS);
  logic start;
  logic [CHANNELS-1:0] chan_mask;
  logic [CNT_W-1:0] result;
  logic [SEL_W-1:0] result_chan;
  logic timeout_flag;
  logic result_valid;
  logic result_ready;
  modport master (output start, chan_mask, result_ready, input result, result_chan, timeout_flag, result_valid);
  modport slave (input start, chan_mask, result_ready, output result, result_chan, timeout_flag, result_valid);
endinterface

// File: rtl/capacitance_scan_controller.sv
// capacitance_scan_controller: time-shares one capacitance front end across mux channels and times reference periods
// clk/rst_n: clock, async active-low reset; reference: async reference state from the switching stage
// front_reset/chan_sel: front-end reset and analog mux select; busy: scan in progress; bus: host scan/result handshake
module capacitance_scan_controller #(
  parameter int CHANNELS = 4,
  parameter logic [15:0] SETTLE = 16'd400,
  parameter int CYCLES = 8,
  parameter int CNT_W = 24,
  parameter logic [CNT_W-1:0] TIMEOUT = 24'd4000000,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reference,
  output logic front_reset,
  output logic [SEL_W-1:0] chan_sel,
  output logic busy,
  capacitance_scan_controller_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ARM, S_MEASURE, S_REPORT} state_t;
  state_t state, nxt;
  logic [1:0] sync;
  logic prev;
  logic [CNT_W-1:0] cnt, timer;
  logic [7:0] edges;
  logic [CHANNELS-1:0] mask;
  logic [SEL_W:0] first_pick, next_pick;
  logic edge_det, tmo, settle_done, last_edge, measuring;
  // {found, index} of the lowest set mask bit at or above from
  function automatic logic [SEL_W:0] pick(input logic [CHANNELS-1:0] m, input int from);
    pick = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (m[i] && i >= from) pick = {1'b1, SEL_W'(i)};
  endfunction
  assign first_pick = pick(bus.chan_mask, 0);
  assign next_pick = pick(mask, int'(chan_sel) + 1);
  assign edge_det = sync[1] ^ prev;
  assign tmo = timer == TIMEOUT;
  assign settle_done = cnt == CNT_W'(SETTLE - 16'd1);
  // the first edge is counted on leaving ARM, so this is edge number 2*CYCLES
  assign last_edge = edges == 8'(2 * CYCLES - 1);
  assign measuring = state == S_ARM || state == S_MEASURE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    front_reset = !measuring;
    busy = state != S_IDLE;
    case (state)
      S_IDLE:    nxt = (bus.start && |bus.chan_mask) ? S_SETTLE : S_IDLE;
      S_SETTLE:  nxt = settle_done ? S_ARM : S_SETTLE;
      S_ARM:     nxt = tmo ? S_REPORT : edge_det ? S_MEASURE : S_ARM;
      S_MEASURE: nxt = (tmo || (edge_det && last_edge)) ? S_REPORT : S_MEASURE;
      S_REPORT:  nxt = !bus.result_ready ? S_REPORT : next_pick[SEL_W] ? S_SETTLE : S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
      cnt <= '0;
      timer <= '0;
      edges <= '0;
      mask <= '0;
      chan_sel <= '0;
      bus.result <= '0;
      bus.result_chan <= '0;
      bus.timeout_flag <= 1'b0;
      bus.result_valid <= 1'b0;
    end else begin
      sync <= {sync[0], reference};
      prev <= sync[1];
      // cnt: settle timer in SETTLE, clocks since the first edge in MEASURE
      cnt <= ((state == S_SETTLE && !settle_done) || state == S_MEASURE) ? cnt + 1'b1 : '0;
      // timer spans ARM and MEASURE without restarting at the first edge
      timer <= measuring ? timer + 1'b1 : '0;
      edges <= state == S_ARM ? 8'd1 : (state == S_MEASURE && edge_det) ? edges + 8'd1 : edges;
      if (state == S_IDLE && nxt == S_SETTLE) begin
        mask <= bus.chan_mask;
        chan_sel <= first_pick[SEL_W-1:0];
      end
      if (state == S_REPORT && nxt == S_SETTLE) chan_sel <= next_pick[SEL_W-1:0];
      if (measuring && nxt == S_REPORT) begin
        bus.result <= tmo ? '1 : cnt + 1'b1;
        bus.result_chan <= chan_sel;
        bus.timeout_flag <= tmo;
        bus.result_valid <= 1'b1;
      end
      if (state == S_REPORT && bus.result_ready) bus.result_valid <= 1'b0;
    end
endmodule

// File: tb/tb_capacitance_scan_controller.sv
// tb_capacitance_scan_controller: scoreboard bench for the capacitance scan controller
module tb_capacitance_scan_controller;
  logic clk = 1'b0;
  logic rst_n;
  logic ref1, ref2;
  logic fr1, fr2, busy1, busy2;
  logic [1:0] sel1, sel2;
  int half, checks, errors;
  typedef struct {logic [1:0] chan; logic [23:0] res; logic tmo;} exp_t;
  exp_t sb[$];
  capacitance_scan_controller_if #(.CHANNELS(4), .CNT_W(24)) bus (), bus2 ();
  capacitance_scan_controller #(.CHANNELS(4), .SETTLE(16'd20), .CYCLES(8), .CNT_W(24), .TIMEOUT(24'd4000)) dut (
    .clk(clk), .rst_n(rst_n), .reference(ref1), .front_reset(fr1), .chan_sel(sel1), .busy(busy1), .bus(bus)
  );
  capacitance_scan_controller #(.CHANNELS(4), .SETTLE(16'd20), .CYCLES(8), .CNT_W(24), .TIMEOUT(24'd1000)) dut_tmo (
    .clk(clk), .rst_n(rst_n), .reference(ref2), .front_reset(fr2), .chan_sel(sel2), .busy(busy2), .bus(bus2)
  );
  always #5 clk = ~clk;
  initial begin
    ref1 = 1'b0;
    forever begin
      if (half == 0) @(posedge clk);
      else begin
        repeat (half) @(posedge clk);
        #3 ref1 = ~ref1;
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && bus.result_valid && bus.result_ready) begin
      chk("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", bus.result, e.res);
        chk("sb_chan", bus.result_chan, e.chan);
        chk("sb_tmo", bus.timeout_flag, e.tmo);
      end
    end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_start(input logic [3:0] m);
    @(posedge clk);
    #1 bus.chan_mask = m;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic settle_len(input string tag);
    int n = 0;
    while (fr1 && n < 100) begin
      tick(1);
      n++;
    end
    chk(tag, n, 20);
  endtask
  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy1 && n < limit) begin
      tick(1);
      n++;
    end
    chk(tag, busy1, 0);
  endtask
  initial begin
    int n, bad;
    logic [23:0] r;
    logic [1:0] c;
    logic f;
    rst_n = 1'b0;
    half = 0;
    ref2 = 1'b0;
    bus.start = 1'b0;
    bus.chan_mask = '0;
    bus.result_ready = 1'b0;
    bus2.start = 1'b0;
    bus2.chan_mask = '0;
    bus2.result_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 bus.start = 1'($urandom);
      bus.chan_mask = 4'($urandom);
      bus.result_ready = 1'($urandom);
      ref2 = 1'($urandom);
    end
    chk("rst_front_reset", fr1, 1);
    chk("rst_chan_sel", sel1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_result_chan", bus.result_chan, 0);
    chk("rst_timeout_flag", bus.timeout_flag, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.result_ready = 1'b1;
    ref2 = 1'b0;
    tick(20);
    chk("idle_busy", busy1, 0);
    pulse_start(4'b0000);
    chk("zero_mask_busy", busy1, 0);
    half = 100;
    sb.push_back('{2'd0, 24'd1500, 1'b0});
    pulse_start(4'b0001);
    chk("single_busy", busy1, 1);
    chk("single_sel", sel1, 0);
    chk("single_front_reset", fr1, 1);
    settle_len("single_settle");
    wait_idle("single_done", 4000);
    half = 50;
    sb.push_back('{2'd1, 24'd750, 1'b0});
    sb.push_back('{2'd3, 24'd750, 1'b0});
    pulse_start(4'b1010);
    chk("multi_sel_first", sel1, 1);
    settle_len("multi_settle");
    tick(100);
    pulse_start(4'b1111);
    n = 0;
    while (sel1 != 2'd3 && n < 4000) begin
      tick(1);
      n++;
    end
    chk("multi_sel_second", sel1, 3);
    wait_idle("multi_done", 4000);
    bus.result_ready = 1'b0;
    sb.push_back('{2'd0, 24'd750, 1'b0});
    sb.push_back('{2'd1, 24'd750, 1'b0});
    pulse_start(4'b0011);
    n = 0;
    while (!bus.result_valid && n < 4000) begin
      tick(1);
      n++;
    end
    chk("bp_valid", bus.result_valid, 1);
    r = bus.result;
    c = bus.result_chan;
    f = bus.timeout_flag;
    bad = 0;
    repeat (50) begin
      tick(1);
      if (bus.result !== r || bus.result_chan !== c || bus.timeout_flag !== f) bad++;
      if (fr1 !== 1'b1 || bus.result_valid !== 1'b1) bad++;
    end
    chk("bp_stable", bad, 0);
    bus.result_ready = 1'b1;
    tick(1);
    chk("bp_valid_drop", bus.result_valid, 0);
    chk("bp_next_sel", sel1, 1);
    chk("bp_next_front_reset", fr1, 1);
    settle_len("bp_settle");
    wait_idle("bp_done", 4000);
    @(posedge clk);
    #1 bus2.chan_mask = 4'b0001;
    bus2.start = 1'b1;
    @(posedge clk);
    #1 bus2.start = 1'b0;
    n = 0;
    while (fr2 && n < 100) begin
      tick(1);
      n++;
    end
    chk("tmo_settle", n, 20);
    n = 0;
    while (!bus2.result_valid && n < 3000) begin
      tick(1);
      n++;
    end
    chk("tmo_latency", n, 1001);
    chk("tmo_result", bus2.result, 32'hFFFFFF);
    chk("tmo_flag", bus2.timeout_flag, 1);
    chk("tmo_chan", bus2.result_chan, 0);
    chk("tmo_front_reset", fr2, 1);
    bus2.result_ready = 1'b1;
    tick(2);
    chk("tmo_idle", busy2, 0);
    half = 100;
    pulse_start(4'b0001);
    settle_len("rst_settle");
    tick(400);
    chk("rst_pre_front_reset", fr1, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_front_reset", fr1, 1);
    chk("rst_mid_valid", bus.result_valid, 0);
    chk("rst_mid_busy", busy1, 0);
    tick(3);
    rst_n = 1'b1;
    sb.push_back('{2'd2, 24'd1500, 1'b0});
    pulse_start(4'b0100);
    chk("rst_new_sel", sel1, 2);
    wait_idle("rst_new_done", 4000);
    tick(2);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
